// File: rtl/v_mem_init_pkg.sv
// Shared types for the memory initialisation engine: write-pattern modes and one-hot FSM states.
// Also reused by the pattern generator, so later BIST engines can share the same mode encoding.
package v_mem_init_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ZERO = 2'd0,
        MODE_FILL = 2'd1,
        MODE_ADDR = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_BUSY = 3'b010,
        S_DONE = 3'b100
    } state_e;

    // The reserved encoding collapses to ZERO so a stray mode can never leak stale data.
    function automatic mode_e decode_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            2'd1:    return MODE_FILL;
            2'd2:    return MODE_ADDR;
            default: return MODE_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/v_mem_init_datagen.sv
// Combinational write-pattern generator: maps (mode, fill word, address) to one data word.
// In ADDR mode the address is zero-extended, or truncated when the word is narrower than the address.
module v_mem_init_datagen
    import v_mem_init_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  mode_e          mode,
    input  logic [W-1:0]   fill,
    input  logic [AW-1:0]  addr,
    output logic [W-1:0]   data
);

    always_comb begin
        data = '0;
        case (mode)
            MODE_FILL: data = fill;
            MODE_ADDR: data = W'(addr);
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/v_mem_init.sv
// Memory initialisation engine: writes an inclusive address range with a pattern, one word per accepted beat.
// Define V_MEM_INIT_AUTO_EN to make the engine zero the whole memory by itself straight out of reset.
//
// state  | meaning
// S_IDLE | waiting for i_start; range is checked here
// S_BUSY | presenting a write; address advances on each accept
// S_DONE | one-cycle completion pulse, then back to idle
module v_mem_init
    import v_mem_init_pkg::*;
#(
    parameter  int N  = 256,
    parameter  int W  = 32,
    localparam int AW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [AW-1:0]     i_base,
    input  logic [AW-1:0]     i_limit,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [W-1:0]      i_fill,
    input  logic              i_abort,
    output logic              o_wen_r,
    input  logic              i_wready,
    output logic [AW-1:0]     o_waddr_r,
    output logic [W-1:0]      o_wdata_r,
    output logic              o_busy_r,
    output logic              o_done_r,
    output logic              o_err_r
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

`ifdef V_MEM_INIT_AUTO_EN
    localparam state_e          RST_STATE = S_BUSY;
    localparam logic [AW-1:0]   RST_LIMIT = LAST;
`else
    localparam state_e          RST_STATE = S_IDLE;
    localparam logic [AW-1:0]   RST_LIMIT = '0;
`endif

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [W-1:0]    fill_q, fill_d;
    logic [AW-1:0]   limit_q, limit_d;
    logic [AW-1:0]   addr_d;
    logic [W-1:0]    data_d;
    logic            err_d;
    logic            accept;

    assign accept = o_wen_r & i_wready;

    // Data is generated from the next-cycle address so the output word is a plain register.
    v_mem_init_datagen #(.W(W), .AW(AW)) u_datagen (
        .mode (mode_d),
        .fill (fill_d),
        .addr (addr_d),
        .data (data_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            mode_q    <= MODE_ZERO;
            fill_q    <= '0;
            limit_q   <= RST_LIMIT;
            o_waddr_r <= '0;
            o_wdata_r <= '0;
            o_wen_r   <= (RST_STATE == S_BUSY);
            o_busy_r  <= (RST_STATE == S_BUSY);
            o_done_r  <= 1'b0;
            o_err_r   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            limit_q   <= limit_d;
            o_waddr_r <= addr_d;
            o_wdata_r <= data_d;
            o_wen_r   <= (state_d == S_BUSY);
            o_busy_r  <= (state_d == S_BUSY);
            o_done_r  <= (state_d == S_DONE);
            o_err_r   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        limit_d = limit_q;
        addr_d  = o_waddr_r;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if ((i_limit < i_base) || (int'(i_limit) > N - 1)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        mode_d  = decode_mode(i_mode);
                        fill_d  = i_fill;
                        limit_d = i_limit;
                        addr_d  = i_base;
                    end
                end
            end
            S_BUSY: begin
                // Limit compare comes first so the address never steps past the range.
                if (accept) begin
                    if (o_waddr_r == limit_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = o_waddr_r + AW'(1);
                    end
                end
                if (i_abort) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
